// File: rtl/msg_scroller.sv
// msg_scroller: maps calculator state to a stored message and drives a registered, scrolling display word.
// Define MSG_BLINK_EN to blink static messages at the tick rate.
module msg_scroller #(
  parameter int DIGITS     = 4,
  parameter int CODE_W     = 5,
  parameter int TICK_DIV   = 25000000,
  parameter int BLANK_CODE = 31
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [3:0]                 state,
  output logic [DIGITS*CODE_W-1:0]   out,
  output logic                       scrolling,
  output logic                       wrap
);
  localparam int OW = $clog2(8 + DIGITS);
  localparam int TW = $clog2(TICK_DIV);

  function automatic int msg_len(input logic [3:0] s);
    return (s == 4'd14) ? 8 : (s == 4'd15) ? 6 :
           (s == 4'd6 || (s >= 4'd8 && s <= 4'd13)) ? 4 : 0;
  endfunction

  // Up to eight 5-bit codes, character 0 in the MSBs.
  function automatic logic [39:0] msg_tab(input logic [3:0] s);
    case (s)
      4'd6:    return {5'd16, 5'd14, 5'd18, 5'd20, 20'd0};
      4'd8:    return {5'd31, 5'd12, 5'd18, 5'd10, 20'd0};
      4'd9:    return {5'd31, 5'd10, 5'd0,  5'd0,  20'd0};
      4'd10:   return {5'd31, 5'd5,  5'd24, 5'd11, 20'd0};
      4'd11:   return {5'd31, 5'd0,  5'd0,  5'd23, 20'd0};
      4'd12:   return {5'd31, 5'd0,  5'd28, 5'd24, 20'd0};
      4'd13:   return {5'd23, 5'd14, 5'd5,  5'd23, 20'd0};
      4'd14:   return {5'd16, 5'd14, 5'd18, 5'd20, 5'd31, 5'd23, 5'd14, 5'd5};
      4'd15:   return {5'd12, 5'd18, 5'd10, 5'd31, 5'd10, 5'd0, 10'd0};
      default: return '0;
    endcase
  endfunction

  // Static messages are right-aligned; scrolling ones index the message-plus-gap ring.
  function automatic logic [CODE_W-1:0] char_at(input logic [39:0] tab, input int len,
                                                 input int off, input int i);
    int k;
    if (len == 0) return '0;
    if (len <= DIGITS) k = i - (DIGITS - len);
    else begin
      k = off + i;
      if (k >= len + DIGITS) k = k - (len + DIGITS);
    end
    return (k >= 0 && k < len) ? CODE_W'(tab[39 - 5*(k & 7) -: 5]) : CODE_W'(BLANK_CODE);
  endfunction

  logic [3:0]               state_q;
  logic [OW-1:0]            offset, offset_n;
  logic [TW-1:0]            tick_cnt, tick_n;
  logic [DIGITS*CODE_W-1:0] out_n;
  logic                     scroll_n, wrap_n, chg, step;
  logic [3:0]               s;
  logic [39:0]              tab;
  int                       len;
`ifdef MSG_BLINK_EN
  logic                     blink_ph, blink_n;
`endif

  always_comb begin
    chg      = state != state_q;
    s        = chg ? state : state_q;
    tab      = msg_tab(s);
    len      = msg_len(s);
    step     = tick_cnt == TW'(TICK_DIV - 1);
    scroll_n = len > DIGITS;
    offset_n = '0;
    tick_n   = '0;
    wrap_n   = 1'b0;
`ifdef MSG_BLINK_EN
    blink_n  = 1'b1;
`endif
    if (!chg && len != 0) begin
      if (len > DIGITS) begin
        tick_n   = step ? '0 : tick_cnt + 1'b1;
        wrap_n   = step && int'(offset) == len + DIGITS - 1;
        offset_n = step ? (wrap_n ? '0 : offset + 1'b1) : offset;
      end
`ifdef MSG_BLINK_EN
      else begin
        tick_n  = step ? '0 : tick_cnt + 1'b1;
        blink_n = step ? ~blink_ph : blink_ph;
      end
`endif
    end
    out_n = '0;
    for (int i = 0; i < DIGITS; i++)
`ifdef MSG_BLINK_EN
      out_n[(DIGITS-1-i)*CODE_W +: CODE_W] = (!blink_n && len <= DIGITS) ? CODE_W'(BLANK_CODE)
                                             : char_at(tab, len, int'(offset_n), i);
`else
      out_n[(DIGITS-1-i)*CODE_W +: CODE_W] = char_at(tab, len, int'(offset_n), i);
`endif
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= '0;
      offset    <= '0;
      tick_cnt  <= '0;
      out       <= '0;
      scrolling <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      state_q   <= state;
      offset    <= offset_n;
      tick_cnt  <= tick_n;
      out       <= out_n;
      scrolling <= scroll_n;
      wrap      <= wrap_n;
    end

`ifdef MSG_BLINK_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) blink_ph <= 1'b1;
    else blink_ph <= blink_n;
`endif
endmodule

// File: tb/tb_msg_scroller.sv
// tb_msg_scroller: scoreboard bench for msg_scroller at DIGITS=4, TICK_DIV=4.
module tb_msg_scroller;
  localparam int TD = 4;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [3:0]  state = 4'd0;
  logic [19:0] out;
  logic        scrolling, wrap;

  typedef struct { logic [19:0] o; logic s; logic w; int id; } exp_t;
  exp_t        q[$];
  exp_t        cur;
  int          n_cmp = 0, n_bad = 0, id = 0;
  logic [19:0] tab[22];
  logic [19:0] w6;

  msg_scroller #(.DIGITS(4), .CODE_W(5), .TICK_DIV(TD), .BLANK_CODE(31)) dut (
    .clk(clk), .rst_n(rst_n), .state(state), .out(out), .scrolling(scrolling), .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] w4(input int a, input int b, input int c, input int d);
    return {5'(a), 5'(b), 5'(c), 5'(d)};
  endfunction

  task automatic check(input string nm, input int n, input logic [19:0] act, input logic [19:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s #%0d: got %h want %h", nm, n, act, exp);
    end
  endtask

  always @(negedge clk)
    if (q.size() != 0) begin
      cur = q.pop_front();
      check("out", cur.id, out, cur.o);
      check("scrolling", cur.id, 20'(scrolling), 20'(cur.s));
      check("wrap", cur.id, 20'(wrap), 20'(cur.w));
    end

  task automatic step(input logic [3:0] st, input logic [19:0] eo, input logic es, input logic ew);
    state = st;
    q.push_back('{eo, es, ew, id});
    id++;
    @(posedge clk);
    #1;
  endtask

  // Each offset is held for TD cycles; the edge at c == TD*p steps back to offset 0 with wrap.
  task automatic scroll_run(input logic [3:0] st, input int base, input int p, input int last);
    for (int c = 0; c <= last; c++) step(st, tab[base + (c / TD) % p], 1'b1, c == TD * p);
  endtask

  task automatic async_clear;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_out", id, out, 20'd0);
    check("async_scrolling", id, 20'(scrolling), 20'd0);
    check("async_wrap", id, 20'(wrap), 20'd0);
  endtask

  initial begin
    w6 = w4(16, 14, 18, 20);
    tab[0]  = w4(16, 14, 18, 20); tab[1]  = w4(14, 18, 20, 31);
    tab[2]  = w4(18, 20, 31, 23); tab[3]  = w4(20, 31, 23, 14);
    tab[4]  = w4(31, 23, 14, 5);  tab[5]  = w4(23, 14, 5, 31);
    tab[6]  = w4(14, 5, 31, 31);  tab[7]  = w4(5, 31, 31, 31);
    tab[8]  = w4(31, 31, 31, 31); tab[9]  = w4(31, 31, 31, 16);
    tab[10] = w4(31, 31, 16, 14); tab[11] = w4(31, 16, 14, 18);
    tab[12] = w4(12, 18, 10, 31); tab[13] = w4(18, 10, 31, 10);
    tab[14] = w4(10, 31, 10, 0);  tab[15] = w4(31, 10, 0, 31);
    tab[16] = w4(10, 0, 31, 31);  tab[17] = w4(0, 31, 31, 31);
    tab[18] = w4(31, 31, 31, 31); tab[19] = w4(31, 31, 31, 12);
    tab[20] = w4(31, 31, 12, 18); tab[21] = w4(31, 12, 18, 10);
    #2;
    check("reset_out", id, out, 20'd0);
    step(4'd5, 20'd0, 1'b0, 1'b0);
    step(4'd5, 20'd0, 1'b0, 1'b0);
    state = 4'd0;
    rst_n = 1'b1;
    repeat (3) step(4'd0, 20'd0, 1'b0, 1'b0);
    repeat (41) step(4'd6, w6, 1'b0, 1'b0);
    step(4'd8,  w4(31, 12, 18, 10), 1'b0, 1'b0);
    step(4'd9,  w4(31, 10, 0, 0),   1'b0, 1'b0);
    step(4'd10, w4(31, 5, 24, 11),  1'b0, 1'b0);
    step(4'd11, w4(31, 0, 0, 23),   1'b0, 1'b0);
    step(4'd12, w4(31, 0, 28, 24),  1'b0, 1'b0);
    repeat (6) step(4'd13, w4(23, 14, 5, 23), 1'b0, 1'b0);
    step(4'd3, 20'd0, 1'b0, 1'b0);
    step(4'd7, 20'd0, 1'b0, 1'b0);
    scroll_run(4'd14, 0, 12, 51);
    step(4'd6, w6, 1'b0, 1'b0);
    scroll_run(4'd14, 0, 12, 23);
    scroll_run(4'd15, 12, 10, 43);
    repeat (2) step(4'd3, 20'd0, 1'b0, 1'b0);
    step(4'd0, 20'd0, 1'b0, 1'b0);
    scroll_run(4'd14, 0, 12, 9);
    async_clear();
    repeat (2) step(4'd14, 20'd0, 1'b0, 1'b0);
    step(4'd0, 20'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (2) step(4'd0, 20'd0, 1'b0, 1'b0);
    step(4'd14, tab[0], 1'b1, 1'b0);
    async_clear();
    step(4'd14, 20'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    scroll_run(4'd14, 0, 12, 5);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
